// File: rtl/cpu_trace_monitor.sv
// Execution-trace monitor for the single-cycle CPU: captures committed
// instructions into a circular buffer and replays them oldest-first.
module cpu_trace_monitor #(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 16,
  parameter int          POST_TRIG = 8,
  parameter logic [5:0]  HALT_OP   = 6'b111111,
  parameter int          TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              arm,
  input  logic [DATA_W-1:0] trig_pc,
  input  logic [DATA_W-1:0] PcOut,
  input  logic [DATA_W-1:0] instruction,
  input  logic              PCWre,
  input  logic              RegWre,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_pc,
  output logic [DATA_W-1:0] rd_ins,
  output logic [DATA_W-1:0] rd_wdata,
  output logic              rd_valid,
  output logic              rd_last,
  output logic [1:0]        state,
  output logic              triggered,
  output logic              halted,
  output logic              timed_out,
  output logic [31:0]       cycle_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] POST_C  = CW'(POST_TRIG);
  localparam logic [32:0]   TMO_C   = 33'(TIMEOUT);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_POST = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Handshake: rd_req is sampled every cycle in DONE; each accepted request
  // returns exactly one entry with rd_valid high on the following cycle.
  // Requests outside DONE or past the final entry are silently dropped.

  logic [DATA_W-1:0] pc_mem  [DEPTH];
  logic [DATA_W-1:0] ins_mem [DEPTH];
  logic [DATA_W-1:0] wd_mem  [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] fill;
  logic [CW-1:0] post_cnt;
  logic [CW-1:0] rd_cnt;

  logic          capturing;
  logic          do_write;
  logic          pc_hit;
  logic          halt_hit;
  logic [CW-1:0] post_next;
  logic [32:0]   cyc_inc;
  logic [31:0]   cyc_next;
  logic          timeout_hit;
  logic [AW-1:0] oldest;
  logic [AW-1:0] rd_addr;
  logic          rd_fire;

  always_comb begin
    capturing   = (state == ST_PRE) || (state == ST_POST);
    do_write    = capturing && PCWre && !arm && !Reset;
    pc_hit      = (PcOut == trig_pc);
    halt_hit    = (instruction[31:26] == HALT_OP);
    post_next   = post_cnt + 1'b1;
    cyc_inc     = {1'b0, cycle_count} + 33'd1;
    cyc_next    = cyc_inc[32] ? 32'hFFFF_FFFF : cyc_inc[31:0];
    timeout_hit = ({1'b0, cyc_next} >= TMO_C);
    // Once the ring has wrapped, the slot about to be overwritten is the oldest.
    oldest      = (fill == DEPTH_C) ? wr_ptr : '0;
    rd_addr     = oldest + rd_cnt[AW-1:0];
    rd_fire     = (state == ST_DONE) && rd_req && (rd_cnt < fill);
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      pc_mem[wr_ptr]  <= PcOut;
      ins_mem[wr_ptr] <= instruction;
      wd_mem[wr_ptr]  <= RegWre ? WriteData : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state       <= ST_IDLE;
      wr_ptr      <= '0;
      fill        <= '0;
      post_cnt    <= '0;
      rd_cnt      <= '0;
      cycle_count <= '0;
      triggered   <= 1'b0;
      halted      <= 1'b0;
      timed_out   <= 1'b0;
      rd_valid    <= 1'b0;
      rd_last     <= 1'b0;
      rd_pc       <= '0;
      rd_ins      <= '0;
      rd_wdata    <= '0;
    end else if (arm) begin
      state       <= ST_PRE;
      wr_ptr      <= '0;
      fill        <= '0;
      post_cnt    <= '0;
      rd_cnt      <= '0;
      cycle_count <= '0;
      triggered   <= 1'b0;
      halted      <= 1'b0;
      timed_out   <= 1'b0;
      rd_valid    <= 1'b0;
      rd_last     <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      case (state)
        ST_PRE, ST_POST: begin
          if (PCWre) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (fill != DEPTH_C) fill <= fill + 1'b1;
            if (state == ST_POST) post_cnt <= post_next;
            if (state == ST_PRE && pc_hit) triggered <= 1'b1;
            // A halt ends the run even when the same sample also triggers.
            if (halt_hit) begin
              halted <= 1'b1;
              state  <= ST_DONE;
            end else if (state == ST_PRE && pc_hit) begin
              state <= (POST_TRIG == 0) ? ST_DONE : ST_POST;
            end else if (state == ST_POST && post_next == POST_C) begin
              state <= ST_DONE;
            end
          end
          cycle_count <= cyc_next;
          if (timeout_hit) begin
            timed_out <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rd_fire) begin
            rd_valid <= 1'b1;
            rd_last  <= ((rd_cnt + 1'b1) == fill);
            rd_pc    <= pc_mem[rd_addr];
            rd_ins   <= ins_mem[rd_addr];
            rd_wdata <= wd_mem[rd_addr];
            rd_cnt   <= rd_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Self-checking bench for cpu_trace_monitor: directed vector table, hand
// sequences for the multi-cycle cases, and random runs against a queue model.
module tb_cpu_trace_monitor;

  localparam int         W         = 32;
  localparam int         DEPTH     = 16;
  localparam int         POST_TRIG = 8;
  localparam int         TIMEOUT   = 45;
  localparam logic [5:0] HALT_OP   = 6'b111111;

  logic          clk = 1'b0;
  logic          Reset, arm, PCWre, RegWre, rd_req;
  logic [W-1:0]  trig_pc, PcOut, instruction, WriteData;
  logic [W-1:0]  rd_pc, rd_ins, rd_wdata;
  logic          rd_valid, rd_last, triggered, halted, timed_out;
  logic [1:0]    state;
  logic [31:0]   cycle_count;

  always #5 clk = ~clk;

  cpu_trace_monitor #(
    .DATA_W(W), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG),
    .HALT_OP(HALT_OP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .Reset(Reset), .arm(arm), .trig_pc(trig_pc),
    .PcOut(PcOut), .instruction(instruction), .PCWre(PCWre),
    .RegWre(RegWre), .WriteData(WriteData), .rd_req(rd_req),
    .rd_pc(rd_pc), .rd_ins(rd_ins), .rd_wdata(rd_wdata),
    .rd_valid(rd_valid), .rd_last(rd_last), .state(state),
    .triggered(triggered), .halted(halted), .timed_out(timed_out),
    .cycle_count(cycle_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: the run is a phase number plus a queue of captured
  // samples, trimmed from the front so at most DEPTH newest survive.
  logic [3*W-1:0] exp_q[$];
  int             m_phase = 0;
  int             m_post  = 0;
  int             m_rd    = 0;
  longint         m_cyc   = 0;
  bit             m_trig = 0, m_halt = 0, m_to = 0, m_rv = 0, m_rl = 0;
  logic [3*W-1:0] m_rdata = '0;

  task automatic model_step();
    bit hit, hlt, fin;
    if (Reset) begin
      m_phase = 0; m_cyc = 0; m_post = 0; m_rd = 0;
      m_trig = 0; m_halt = 0; m_to = 0; m_rv = 0; m_rl = 0;
      m_rdata = '0; exp_q.delete();
    end else if (arm) begin
      m_phase = 1; m_cyc = 0; m_post = 0; m_rd = 0;
      m_trig = 0; m_halt = 0; m_to = 0; m_rv = 0; m_rl = 0;
      exp_q.delete();
    end else begin
      m_rv = 0; m_rl = 0;
      if (m_phase == 3) begin
        if (rd_req && m_rd < exp_q.size()) begin
          m_rv = 1;
          m_rdata = exp_q[m_rd];
          m_rl = (m_rd == exp_q.size() - 1);
          m_rd++;
        end
      end else if (m_phase == 1 || m_phase == 2) begin
        fin = 0;
        if (PCWre) begin
          exp_q.push_back({PcOut, instruction, RegWre ? WriteData : '0});
          if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
          hit = (PcOut == trig_pc);
          hlt = (instruction[31:26] == HALT_OP);
          if (m_phase == 2) m_post++;
          if (m_phase == 1 && hit) m_trig = 1;
          if (hlt) begin
            m_halt = 1; fin = 1;
          end else if (m_phase == 1 && hit) begin
            if (POST_TRIG == 0) fin = 1; else m_phase = 2;
          end else if (m_phase == 2 && m_post == POST_TRIG) begin
            fin = 1;
          end
        end
        if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
        if (m_cyc >= TIMEOUT) begin
          m_to = 1; fin = 1;
        end
        if (fin) m_phase = 3;
      end
    end
  endtask

  task automatic check_all();
    chk("state", 64'(state), 64'(m_phase));
    chk("triggered", 64'(triggered), 64'(m_trig));
    chk("halted", 64'(halted), 64'(m_halt));
    chk("timed_out", 64'(timed_out), 64'(m_to));
    chk("cycle_count", 64'(cycle_count), 64'(m_cyc[31:0]));
    chk("rd_valid", 64'(rd_valid), 64'(m_rv));
    chk("rd_last", 64'(rd_last), 64'(m_rl));
    chk("rd_pc", 64'(rd_pc), 64'(m_rdata[3*W-1:2*W]));
    chk("rd_ins", 64'(rd_ins), 64'(m_rdata[2*W-1:W]));
    chk("rd_wdata", 64'(rd_wdata), 64'(m_rdata[W-1:0]));
  endtask

  // Inputs are set at posedge+1; the model sees them at the next posedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input logic a, input logic p, input logic rw, input logic rq,
                       input logic [W-1:0] pcv, input logic [W-1:0] insv,
                       input logic [W-1:0] wdv);
    arm = a; PCWre = p; RegWre = rw; rd_req = rq;
    PcOut = pcv; instruction = insv; WriteData = wdv;
  endtask

  typedef struct {
    logic         a;
    logic         p;
    logic [W-1:0] pcv;
    logic [W-1:0] insv;
    logic         rq;
    logic [1:0]   e_state;
    logic         e_halted;
    logic         e_rv;
    logic [W-1:0] e_rpc;
    logic         e_rl;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 32'h0,  32'h0,         1'b0, 2'd1, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[1]  = '{1'b0, 1'b1, 32'h0,  32'h0000_0001, 1'b0, 2'd1, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[2]  = '{1'b0, 1'b1, 32'h4,  32'h0800_0002, 1'b0, 2'd1, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[3]  = '{1'b0, 1'b1, 32'h8,  32'h1000_0003, 1'b0, 2'd1, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[4]  = '{1'b0, 1'b1, 32'hC,  32'h2000_0004, 1'b0, 2'd1, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[5]  = '{1'b0, 1'b1, 32'h10, 32'hFC00_0000, 1'b0, 2'd3, 1'b1, 1'b0, 32'h0,  1'b0};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 2'd3, 1'b1, 1'b1, 32'h0,  1'b0};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 2'd3, 1'b1, 1'b1, 32'h4,  1'b0};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 2'd3, 1'b1, 1'b1, 32'h8,  1'b0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 2'd3, 1'b1, 1'b1, 32'hC,  1'b0};
    tbl[10] = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 2'd3, 1'b1, 1'b1, 32'h10, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 2'd3, 1'b1, 1'b0, 32'h0,  1'b0};

    // Reset
    Reset = 1'b1; trig_pc = '0;
    drive(0, 0, 0, 0, '0, '0, '0);
    tick(); tick();
    Reset = 1'b0;
    chk("reset_state", 64'(state), 64'(0));
    chk("reset_rd_valid", 64'(rd_valid), 64'(0));
    chk("reset_cycle_count", 64'(cycle_count), 64'(0));

    // Halt run from the vector table
    trig_pc = 32'hFFFF_FFF0;
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].a, tbl[i].p, 1'b1, tbl[i].rq, tbl[i].pcv, tbl[i].insv, tbl[i].pcv + 32'd1);
      tick();
      chk("tbl_state", 64'(state), 64'(tbl[i].e_state));
      chk("tbl_halted", 64'(halted), 64'(tbl[i].e_halted));
      chk("tbl_rd_valid", 64'(rd_valid), 64'(tbl[i].e_rv));
      if (tbl[i].e_rv) begin
        chk("tbl_rd_pc", 64'(rd_pc), 64'(tbl[i].e_rpc));
        chk("tbl_rd_last", 64'(rd_last), 64'(tbl[i].e_rl));
      end
    end

    // Trigger at PC 0x28 with 8 post-trigger samples
    trig_pc = 32'h28;
    drive(1, 0, 0, 0, '0, '0, '0); tick();
    for (int i = 0; i < 30; i++) begin
      drive(0, 1, 1, 0, 32'(4 * i), 32'(i), 32'(3 * i));
      tick();
      if (i == 10) begin
        chk("trig_state_post", 64'(state), 64'(2));
        chk("trig_flag", 64'(triggered), 64'(1));
      end
      if (i == 18) chk("trig_state_done", 64'(state), 64'(3));
    end
    for (int k = 0; k < 16; k++) begin
      drive(0, 0, 0, 1, '0, '0, '0); tick();
      chk("trig_rd_valid", 64'(rd_valid), 64'(1));
      chk("trig_rd_pc", 64'(rd_pc), 64'(32'h0C + 4 * k));
      chk("trig_rd_last", 64'(rd_last), 64'(k == 15));
    end
    tick();
    chk("trig_rd_exhausted", 64'(rd_valid), 64'(0));

    // Timeout with no commits
    trig_pc = 32'hFFFF_FFF0;
    drive(1, 0, 0, 0, '0, '0, '0); tick();
    drive(0, 0, 0, 0, '0, '0, '0);
    for (int t = 1; t <= TIMEOUT; t++) begin
      tick();
      if (t == TIMEOUT - 1) chk("tmo_still_pre", 64'(state), 64'(1));
    end
    chk("tmo_state", 64'(state), 64'(3));
    chk("tmo_flag", 64'(timed_out), 64'(1));
    chk("tmo_count", 64'(cycle_count), 64'(TIMEOUT));
    drive(0, 0, 0, 1, '0, '0, '0); tick();
    chk("tmo_empty_read", 64'(rd_valid), 64'(0));
    chk("tmo_count_hold", 64'(cycle_count), 64'(TIMEOUT));

    // Wrap: 40 commits, then timeout ends the run
    drive(1, 0, 0, 0, '0, '0, '0); tick();
    for (int i = 0; i < 40; i++) begin
      drive(0, 1, logic'(i % 2), 0, 32'(4 * i), 32'h0400_0000 | 32'(i), 32'hA000 + 32'(i));
      tick();
    end
    drive(0, 0, 0, 0, '0, '0, '0);
    for (int t = 0; t < 5; t++) tick();
    chk("wrap_state", 64'(state), 64'(3));
    chk("wrap_timed_out", 64'(timed_out), 64'(1));
    for (int k = 0; k < 16; k++) begin
      drive(0, 0, 0, 1, '0, '0, '0); tick();
      chk("wrap_rd_pc", 64'(rd_pc), 64'(4 * (24 + k)));
      chk("wrap_rd_wdata", 64'(rd_wdata), ((24 + k) % 2 == 1) ? 64'(32'hA000 + 24 + k) : 64'(0));
      chk("wrap_rd_last", 64'(rd_last), 64'(k == 15));
    end

    // Reset in POST, re-arm, then arm during readout
    trig_pc = 32'h20;
    drive(1, 0, 0, 0, '0, '0, '0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, 0, 32'h18 + 32'(4 * i), 32'(i), 32'(i)); tick();
    end
    chk("mid_post_state", 64'(state), 64'(2));
    Reset = 1'b1; drive(0, 1, 1, 1, 32'h28, '0, '0); tick();
    Reset = 1'b0;
    chk("rst_post_state", 64'(state), 64'(0));
    chk("rst_post_triggered", 64'(triggered), 64'(0));
    chk("rst_post_count", 64'(cycle_count), 64'(0));
    drive(1, 0, 0, 0, '0, '0, '0); tick();
    drive(0, 1, 1, 0, 32'h100, 32'h1, 32'h7); tick();
    drive(0, 1, 1, 0, 32'h104, 32'h2, 32'h8); tick();
    drive(0, 1, 1, 0, 32'h108, 32'hFC00_0000, 32'h9); tick();
    chk("rearm_halted", 64'(halted), 64'(1));
    drive(0, 0, 0, 1, '0, '0, '0); tick();
    chk("rearm_rd0", 64'(rd_pc), 64'(32'h100));
    tick();
    chk("rearm_rd1", 64'(rd_pc), 64'(32'h104));
    drive(1, 0, 0, 1, '0, '0, '0); tick();
    chk("arm_in_done_state", 64'(state), 64'(1));
    chk("arm_in_done_rv", 64'(rd_valid), 64'(0));

    // Random runs against the model
    for (int run = 0; run < 40; run++) begin
      trig_pc = 32'h40 + 32'(4 * $urandom_range(0, 31));
      drive(1, 0, 0, 0, '0, '0, '0); tick();
      for (int c = 0; c < 60; c++) begin
        logic [W-1:0] insv;
        if ($urandom_range(0, 39) == 0) insv = {HALT_OP, 26'($urandom)};
        else insv = {6'($urandom_range(0, 62)), 26'($urandom)};
        Reset = ($urandom_range(0, 199) == 0);
        drive(logic'($urandom_range(0, 99) == 0), logic'($urandom_range(0, 3) != 0),
              logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
              32'h40 + 32'(4 * $urandom_range(0, 31)), insv, $urandom);
        tick();
      end
      Reset = 1'b0;
      drive(0, 0, 0, 1, '0, '0, '0);
      for (int c = 0; c < 20; c++) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
